// File: rtl/params.sv
// Shared widths and types for the multiply-and-add datapath and its inverse.
package params;
  localparam int INPUT_SIZE  = 8;
  localparam int OUTPUT_SIZE = 17;

  typedef enum logic [1:0] {IDLE, SUBTRACT, DIVIDE, DONE} inv_state_t;
  typedef logic [OUTPUT_SIZE-1:0] wide_t;
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int INPUT_SIZE = 8
) (
  input  logic [INPUT_SIZE:0]   i_rem,
  input  logic                  i_dividend_bit,
  input  logic [INPUT_SIZE-1:0] i_divisor,
  output logic [INPUT_SIZE:0]   o_rem,
  output logic                  o_quot_bit
);
  logic [INPUT_SIZE+1:0] w_shift;
  logic [INPUT_SIZE+1:0] w_sub;

  always_comb begin
    w_shift    = {i_rem, i_dividend_bit};
    w_sub      = w_shift - {2'b00, i_divisor};
    o_quot_bit = (w_shift >= {2'b00, i_divisor});
    // The kept remainder is always below the divisor, so the top bit drops safely.
    o_rem      = o_quot_bit ? w_sub[INPUT_SIZE:0] : w_shift[INPUT_SIZE:0];
  end
endmodule

// File: rtl/multiply_and_add_inverse.sv
// Recovers A = (result - C) / B with remainder using a bit-serial restoring divider.
// Optional MULADD_RANGE_CHECK_EN adds a_overflow (quotient wider than INPUT_SIZE bits).
module multiply_and_add_inverse
  import params::inv_state_t, params::IDLE, params::SUBTRACT, params::DIVIDE, params::DONE;
#(
  parameter int INPUT_SIZE  = params::INPUT_SIZE,
  parameter int OUTPUT_SIZE = params::OUTPUT_SIZE
) (
  input  logic                   clock,
  input  logic                   reset_n,
  // Handshakes: a transfer occurs on a rising edge where valid and ready are both 1;
  // the source holds valid and data stable until then.
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OUTPUT_SIZE-1:0] result,
  input  logic [INPUT_SIZE-1:0]  B,
  input  logic [INPUT_SIZE-1:0]  C,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUTPUT_SIZE-1:0] A,
  output logic [OUTPUT_SIZE-1:0] remainder,
  output logic                   err_div0,
  output logic                   err_underflow,
`ifdef MULADD_RANGE_CHECK_EN
  output logic                   a_overflow,
`endif
  output inv_state_t             dbg_state
);
  localparam int CNT_W = $clog2(OUTPUT_SIZE);
  localparam int REM_W = INPUT_SIZE + 1;

  inv_state_t             r_state;
  logic [OUTPUT_SIZE-1:0] r_result;
  logic [INPUT_SIZE-1:0]  r_b;
  logic [INPUT_SIZE-1:0]  r_c;
  logic [OUTPUT_SIZE-1:0] r_dividend;
  logic [OUTPUT_SIZE-2:0] r_quot;
  logic [REM_W-1:0]       r_part_rem;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic [OUTPUT_SIZE-1:0] r_a;
  logic [OUTPUT_SIZE-1:0] r_remainder;
  logic                   r_err_div0;
  logic                   r_err_underflow;
`ifdef MULADD_RANGE_CHECK_EN
  logic                   r_a_overflow;
`endif

  logic [OUTPUT_SIZE:0]   w_diff;
  logic                   w_borrow;
  logic [REM_W-1:0]       w_step_rem;
  logic                   w_qbit;
  logic [OUTPUT_SIZE-1:0] w_quot_next;

  // One extra bit on the subtraction exposes the borrow for result < C.
  assign w_diff      = {1'b0, r_result} - {{(OUTPUT_SIZE+1-INPUT_SIZE){1'b0}}, r_c};
  assign w_borrow    = w_diff[OUTPUT_SIZE];
  assign w_quot_next = {r_quot, w_qbit};

  div_step #(.INPUT_SIZE(INPUT_SIZE)) u_div_step (
    .i_rem          (r_part_rem),
    .i_dividend_bit (r_dividend[OUTPUT_SIZE-1]),
    .i_divisor      (r_b),
    .o_rem          (w_step_rem),
    .o_quot_bit     (w_qbit)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= IDLE;
      r_result        <= '0;
      r_b             <= '0;
      r_c             <= '0;
      r_dividend      <= '0;
      r_quot          <= '0;
      r_part_rem      <= '0;
      r_cnt           <= '0;
      r_in_ready      <= 1'b1;
      r_out_valid     <= 1'b0;
      r_a             <= '0;
      r_remainder     <= '0;
      r_err_div0      <= 1'b0;
      r_err_underflow <= 1'b0;
`ifdef MULADD_RANGE_CHECK_EN
      r_a_overflow    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_result        <= result;
            r_b             <= B;
            r_c             <= C;
            r_err_div0      <= 1'b0;
            r_err_underflow <= 1'b0;
            r_in_ready      <= 1'b0;
            r_state         <= SUBTRACT;
          end
        end
        SUBTRACT: begin
          if (w_borrow) begin
            r_err_underflow <= 1'b1;
            r_a             <= '0;
            r_remainder     <= '0;
`ifdef MULADD_RANGE_CHECK_EN
            r_a_overflow    <= 1'b0;
`endif
            r_out_valid     <= 1'b1;
            r_state         <= DONE;
          end else if (r_b == '0) begin
            r_err_div0      <= 1'b1;
            r_a             <= '1;
            r_remainder     <= w_diff[OUTPUT_SIZE-1:0];
`ifdef MULADD_RANGE_CHECK_EN
            r_a_overflow    <= 1'b0;
`endif
            r_out_valid     <= 1'b1;
            r_state         <= DONE;
          end else begin
            r_dividend      <= w_diff[OUTPUT_SIZE-1:0];
            r_part_rem      <= '0;
            r_quot          <= '0;
            r_cnt           <= CNT_W'(OUTPUT_SIZE - 1);
            r_state         <= DIVIDE;
          end
        end
        DIVIDE: begin
          r_dividend <= {r_dividend[OUTPUT_SIZE-2:0], 1'b0};
          r_part_rem <= w_step_rem;
          r_quot     <= w_quot_next[OUTPUT_SIZE-2:0];
          r_cnt      <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) begin
            r_a          <= w_quot_next;
            r_remainder  <= {{(OUTPUT_SIZE-REM_W){1'b0}}, w_step_rem};
`ifdef MULADD_RANGE_CHECK_EN
            r_a_overflow <= |w_quot_next[OUTPUT_SIZE-1:INPUT_SIZE];
`endif
            r_out_valid  <= 1'b1;
            r_state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign A             = r_a;
  assign remainder     = r_remainder;
  assign err_div0      = r_err_div0;
  assign err_underflow = r_err_underflow;
`ifdef MULADD_RANGE_CHECK_EN
  assign a_overflow    = r_a_overflow;
`endif
  assign dbg_state     = r_state;
endmodule

// File: tb/tb_multiply_and_add_inverse.sv
// Directed bench for multiply_and_add_inverse with hand-computed expected values.
module tb_multiply_and_add_inverse;
  import params::*;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  wide_t      result;
  logic [7:0] B;
  logic [7:0] C;
  logic       out_valid;
  logic       out_ready;
  wide_t      A;
  wide_t      remainder;
  logic       err_div0;
  logic       err_underflow;
`ifdef MULADD_RANGE_CHECK_EN
  logic       a_overflow;
`endif
  inv_state_t dbg_state;

  int total = 0;
  int bad   = 0;
  logic [2*OUTPUT_SIZE-1:0] exp_q[$];

  multiply_and_add_inverse dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .result        (result),
    .B             (B),
    .C             (C),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .A             (A),
    .remainder     (remainder),
    .err_div0      (err_div0),
    .err_underflow (err_underflow),
`ifdef MULADD_RANGE_CHECK_EN
    .a_overflow    (a_overflow),
`endif
    .dbg_state     (dbg_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one transaction, returns at the negedge where out_valid is seen.
  task automatic run_txn(input string tag, input wide_t res, input logic [7:0] b,
                         input logic [7:0] c, input int exp_lat);
    int lat;
    int w;
    bit rdy_low;
    w = 0;
    @(negedge clock);
    while (!in_ready && w < 60) begin
      @(negedge clock);
      w++;
    end
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    result   = res;
    B        = b;
    C        = c;
    in_valid = 1'b1;
    @(posedge clock);
    lat = 1;
    @(negedge clock);
    in_valid = 1'b0;
    rdy_low  = 1'b1;
    while (!out_valid && lat < 60) begin
      if (in_ready) rdy_low = 1'b0;
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    if (in_ready) rdy_low = 1'b0;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_ready_low"}, {31'd0, rdy_low}, 32'd1);
  endtask

  task automatic check_out(input string tag, input wide_t exp_a, input wide_t exp_r,
                           input logic exp_d0, input logic exp_uf, input logic exp_ovf);
    check({tag, "_A"}, A, exp_a);
    check({tag, "_rem"}, remainder, exp_r);
    check({tag, "_div0"}, {31'd0, err_div0}, {31'd0, exp_d0});
    check({tag, "_uflow"}, {31'd0, err_underflow}, {31'd0, exp_uf});
`ifdef MULADD_RANGE_CHECK_EN
    check({tag, "_ovf"}, {31'd0, a_overflow}, {31'd0, exp_ovf});
`else
    if (exp_ovf) total += 0;
`endif
  endtask

  task automatic finish_out(input string tag);
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    bit stable;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    result    = '0;
    B         = '0;
    C         = '0;
    repeat (3) @(negedge clock);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_A", A, 32'd0);
    check("rst_rem", remainder, 32'd0);
    check("rst_errs", {30'd0, err_div0, err_underflow}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    reset_n = 1'b1;

    // (22-7)/5 = 3 r 0
    run_txn("basic", 17'd22, 8'd5, 8'd7, 19);
    check_out("basic", 17'd3, 17'd0, 1'b0, 1'b0, 1'b0);
    finish_out("basic");

    // (65280-255)/255 = 255 r 0, fits 8 bits
    run_txn("max8", 17'd65280, 8'd255, 8'd255, 19);
    check_out("max8", 17'd255, 17'd0, 1'b0, 1'b0, 1'b0);
    finish_out("max8");

    run_txn("b1", 17'd65280, 8'd1, 8'd0, 19);
    check_out("b1", 17'd65280, 17'd0, 1'b0, 1'b0, 1'b1);
    finish_out("b1");

    // 991 = 13*76 + 3
    run_txn("mid", 17'd1000, 8'd13, 8'd9, 19);
    check_out("mid", 17'd76, 17'd3, 1'b0, 1'b0, 1'b0);
    finish_out("mid");

    // 39 = 6*6 + 3, then held under backpressure
    out_ready = 1'b0;
    run_txn("bp", 17'd40, 8'd6, 8'd1, 19);
    check_out("bp", 17'd6, 17'd3, 1'b0, 1'b0, 1'b0);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || A !== 17'd6 || remainder !== 17'd3)
        stable = 1'b0;
    end
    check("bp_hold", {31'd0, stable}, 32'd1);
    finish_out("bp");

    run_txn("div0", 17'd30, 8'd0, 8'd4, 2);
    check_out("div0", 17'h1FFFF, 17'd26, 1'b1, 1'b0, 1'b0);
    finish_out("div0");

    run_txn("uflow", 17'd5, 8'd3, 8'd7, 2);
    check_out("uflow", 17'd0, 17'd0, 1'b0, 1'b1, 1'b0);
    finish_out("uflow");

    // 131071 = 255*514 + 1
    run_txn("top", 17'h1FFFF, 8'd255, 8'd0, 19);
    check_out("top", 17'd514, 17'd1, 1'b0, 1'b0, 1'b1);
    finish_out("top");

    // Reset in the middle of DIVIDE
    @(negedge clock);
    result   = 17'd100;
    B        = 8'd7;
    C        = 8'd2;
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (5) begin
      @(posedge clock);
      @(negedge clock);
    end
    check("mid_rst_pre_state", {30'd0, dbg_state}, {30'd0, DIVIDE});
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_A", A, 32'd0);
    check("mid_rst_rem", remainder, 32'd0);
    check("mid_rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    @(negedge clock);
    reset_n = 1'b1;
    run_txn("post_rst", 17'd100, 8'd7, 8'd2, 19);
    check_out("post_rst", 17'd14, 17'd0, 1'b0, 1'b0, 1'b0);
    finish_out("post_rst");

    // Back-to-back with in_valid held high
    out_ready = 1'b1;
    exp_q.push_back({17'd12, 17'd0});
    exp_q.push_back({17'd22, 17'd2});
    exp_q.push_back({17'd7, 17'd1});
    fork
      begin
        wide_t rv[3];
        logic [7:0] bv[3];
        logic [7:0] cv[3];
        rv[0] = 17'd50;  bv[0] = 8'd4;  cv[0] = 8'd2;
        rv[1] = 17'd200; bv[1] = 8'd9;  cv[1] = 8'd0;
        rv[2] = 17'd77;  bv[2] = 8'd10; cv[2] = 8'd6;
        for (int t = 0; t < 3; t++) begin
          int w;
          w = 0;
          @(negedge clock);
          while (!in_ready && w < 60) begin
            @(negedge clock);
            w++;
          end
          check("b2b_accept_idle", {30'd0, dbg_state}, {30'd0, IDLE});
          result   = rv[t];
          B        = bv[t];
          C        = cv[t];
          in_valid = 1'b1;
          @(posedge clock);
        end
        @(negedge clock);
        in_valid = 1'b0;
      end
      begin
        int pulses;
        logic [2*OUTPUT_SIZE-1:0] e;
        pulses = 0;
        for (int cyc = 0; cyc < 150; cyc++) begin
          @(negedge clock);
          if (out_valid) begin
            pulses++;
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("b2b_A", A, e[2*OUTPUT_SIZE-1:OUTPUT_SIZE]);
              check("b2b_rem", remainder, e[OUTPUT_SIZE-1:0]);
            end
          end
        end
        check("b2b_pulses", pulses, 32'd3);
        check("b2b_queue_empty", exp_q.size(), 32'd0);
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multiply_and_add_inverse.md
Name: multiply_and_add_inverse

Overview:
Recovers operand A from a multiply-and-add result: A = (result - C) / B, with remainder. This is the decoder for the A*B+C datapath and is used to check or unpack results read back from the streams. A one-bit-per-cycle restoring divider sits behind a valid/ready input and output handshake. It processes one transaction at a time; each transaction carries its own B and C.

Parameters:
INPUT_SIZE, params::INPUT_SIZE (8), width of B, C and the nominal A
OUTPUT_SIZE, params::OUTPUT_SIZE (17), width of result, quotient and remainder

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  input transaction valid
in_ready  out  1  block can accept an input
result  in  OUTPUT_SIZE  multiply-and-add value to invert
B  in  INPUT_SIZE  divisor
C  in  INPUT_SIZE  addend to remove
out_valid  out  1  quotient/remainder valid
out_ready  in  1  consumer accepts the output
A  out  OUTPUT_SIZE  quotient (result-C)/B
remainder  out  OUTPUT_SIZE  (result-C) mod B
err_div0  out  1  B was zero
err_underflow  out  1  result < C

Behaviour:
- Reset (asynchronous, reset_n=0) is immediate:
  - state=IDLE; in_ready=1; out_valid=0.
  - A, remainder, err_div0, err_underflow all 0.
  - Any transaction in flight is discarded with no output.
- States: IDLE, SUBTRACT, DIVIDE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at a rising edge, latch result, B and C, clear both error flags, and go to SUBTRACT.
- SUBTRACT (1 cycle): compute diff = result - zero-extended C, one bit wider than OUTPUT_SIZE.
  - Borrow: err_underflow=1, A=0, remainder=0, go to DONE.
  - Else if B==0: err_div0=1, A=all ones, remainder=diff, go to DONE.
  - Else: load the dividend with diff, clear the partial remainder, iteration counter=OUTPUT_SIZE-1, go to DIVIDE.
- DIVIDE (exactly OUTPUT_SIZE cycles), each cycle:
  - Shift the partial remainder left by one and bring in the dividend MSB.
  - If partial remainder >= B, subtract B and shift 1 into the quotient; otherwise shift in 0.
  - When the counter reaches 0, go to DONE. The counter is $clog2(OUTPUT_SIZE) bits.
- DONE:
  - out_valid=1; A, remainder and error flags are stable.
  - Stay in DONE while out_ready=0 (backpressure; outputs held).
  - On out_valid&out_ready, go to IDLE with out_valid=0 on the next cycle.
- in_ready=0 in every state except IDLE. There is no input/output overlap: a new input is accepted earliest one cycle after the output handshake.
- Latency from the accepting edge to out_valid=1:
  - Normal: OUTPUT_SIZE+2 clocks (19 at defaults).
  - Error cases: 2 clocks.
- Width rules:
  - The remainder register is INPUT_SIZE+1 bits internally, zero-extended on output.
  - The quotient is OUTPUT_SIZE bits, so no truncation is possible.
- Simultaneous events: in_valid asserted while not in IDLE is ignored (the source must hold it until in_ready). out_ready outside DONE has no effect.

Optional Feature:
- MULADD_RANGE_CHECK_EN defined:
  - Adds output port a_overflow (1 bit), reset 0, updated on entry to DONE.
  - a_overflow=1 when the quotient exceeds 2^INPUT_SIZE-1, i.e. A does not fit the multiplier input width.
  - a_overflow is forced 0 when either error flag is set.
- Not defined: the port is absent and no compare logic is built.

Decomposition:
- Package params: INPUT_SIZE and OUTPUT_SIZE (existing).
- Add to params:
  - typedef enum logic [1:0] {IDLE, SUBTRACT, DIVIDE, DONE} inv_state_t.
  - typedef logic [OUTPUT_SIZE-1:0] wide_t.
- One sub-module is natural: div_step, the combinational single restoring step. Inputs: partial remainder, next dividend bit, divisor. Outputs: new remainder and quotient bit. Instantiated once and used for all OUTPUT_SIZE iterations.

Test Plan:
- result=22, B=5, C=7, out_ready=1 -> out_valid 19 clocks after acceptance; A=3, remainder=0, both errors 0; in_ready=0 throughout.
- result=65280, B=255, C=255 -> A=255, remainder=0. With MULADD_RANGE_CHECK_EN: a_overflow=0. Then result=65280, B=1, C=0 -> A=65280, a_overflow=1.
- result=40, B=6, C=1 -> A=6, remainder=3. Hold out_ready=0 for 10 cycles: outputs and out_valid stable, in_ready=0. Release: out_valid drops next cycle, in_ready=1.
- result=30, B=0, C=4 -> 2 clocks later err_div0=1, A=0x1FFFF, remainder=26. Then result=5, B=3, C=7 -> err_underflow=1, A=0, remainder=0, err_div0=0.
- Start result=100, B=7, C=2, assert reset_n=0 at DIVIDE cycle 5 -> outputs and out_valid immediately 0, in_ready=1. After release, result=100, B=7, C=2 -> A=14, remainder=0.
- Back-to-back: in_valid held high with 3 queued transactions -> each accepted only in IDLE; exactly 3 out_valid pulses with correct values in order.
